// File: rtl/ones_frame_accum.sv
// ones_frame_accum: sums FRAME_LEN 3-bit ones counts into one frame total and
// presents it with majority/saturation flags over a valid/ready handshake.
// Optional feature macro: ONES_ACCUM_PEAK_EN adds out_peak, the largest count
// accepted in the frame.
module ones_frame_accum #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [2:0]       in_cnt,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_maj,
    output logic             out_sat
`ifdef ONES_ACCUM_PEAK_EN
    ,
    output logic [2:0]       out_peak
`endif
);

    // Accumulator sized for the largest possible frame total, so it never wraps.
    localparam int          ACC_W   = $clog2(7 * FRAME_LEN + 1);
    localparam logic [7:0]  LAST    = 8'(FRAME_LEN - 1);
    localparam logic [31:0] SAT_MAX = 32'((64'd1 << SUM_W) - 64'd1);
    localparam logic [31:0] MAJ_THR = 32'(7 * FRAME_LEN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             maj_q, maj_d;
    logic             sat_q, sat_d;

    logic        accept;
    logic        last_accept;
    logic [31:0] total;
    logic        total_sat;

    assign accept      = in_valid && (state_q == ACCUM);
    assign last_accept = accept && (cnt_q == LAST);
    // Frame total including the word being accepted this cycle.
    assign total       = 32'(acc_q) + 32'(in_cnt);
    assign total_sat   = (total > SAT_MAX);

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = sum_q;
    assign out_maj   = maj_q;
    assign out_sat   = sat_q;

    // State and result registers; reset returns to an empty frame with cleared outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            maj_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            maj_q   <= maj_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic: clear overrides everything, then accumulate or wait for handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        maj_d   = maj_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            sum_d   = '0;
            maj_d   = 1'b0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_accept) begin
                        sum_d   = total_sat ? SUM_W'(SAT_MAX) : total[SUM_W-1:0];
                        maj_d   = ({total[30:0], 1'b0} > MAJ_THR);
                        sat_d   = total_sat;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = HOLD;
                    end else if (accept) begin
                        acc_d = acc_q + ACC_W'(in_cnt);
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

`ifdef ONES_ACCUM_PEAK_EN
    logic [2:0] peak_q, peak_d;
    logic [2:0] opeak_q, opeak_d;
    logic [2:0] peak_new;

    assign peak_new = (in_cnt > peak_q) ? in_cnt : peak_q;
    assign out_peak = opeak_q;

    // Running peak and its published copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q  <= '0;
            opeak_q <= '0;
        end else begin
            peak_q  <= peak_d;
            opeak_q <= opeak_d;
        end
    end

    // Peak tracks accepted words; it is published with the sum and restarts each frame.
    always_comb begin
        peak_d  = peak_q;
        opeak_d = opeak_q;
        if (clear) begin
            peak_d  = '0;
            opeak_d = '0;
        end else if (last_accept) begin
            opeak_d = peak_new;
            peak_d  = '0;
        end else if (accept) begin
            peak_d = peak_new;
        end
    end
`endif

endmodule
